spi_slave_device: RTL and testbench
===================================

# spi_slave_device

SPI mode-0 slave that receives an `outBits`-wide word on MOSI and simultaneously returns a preloaded word on MISO, MSB first. It is the far-end counterpart of the team's SPI master device, for FPGA-side endpoints addressed by an external master (MBED or a second FPGA). SCK, CSbar and MOSI are oversampled on the system clock; no logic runs on SCK.

## Interface
- `outBits`, 16: word width, 2..32.
- `SYS_CLK`  in  1  system clock; single clock domain. Reset is synchronous and active-high.
- `SYS_RST`  in  1  synchronous, active-high reset.
- `SCK`  in  1  SPI clock from the master; asynchronous.
- `CSbar`  in  1  active-low chip select; asynchronous.
- `MOSI`  in  1  serial data from the master; asynchronous.
- `MISO`  out  1  serial data to the master.
- `TX_DATA`  in  outBits  word to return in the next frame.
- `TX_LOAD`  in  1  one-cycle strobe that captures TX_DATA into the hold register.
- `RX_DATA`  out  outBits  last complete received word; held until the next complete frame.
- `RX_VALID`  out  1  one-cycle pulse when RX_DATA updates.
- `BUSY`  out  1  high while a frame is in progress (SHIFT or DONE).
- `FRAME_ERR`  out  1  one-cycle pulse when CSbar deasserts mid-word.

## Operation
- Synchronizers: 2-FF synchronizers on SCK, CSbar and MOSI, plus one history stage on SCK and CSbar for edge detection. Edge strobes (`sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`) are one cycle wide.
- Hold register `tx_hold`: loaded on TX_LOAD in any state. If TX_LOAD coincides with `cs_fall`, the new TX_DATA is shifted out (bypass).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on `cs_fall`: load `tx_shift` from `tx_hold`, clear `bitcnt` and `rx_shift`, then go to SHIFT.
  - SHIFT, on `sck_rise`: `rx_shift <= {rx_shift[outBits-2:0], mosi_s}` and `bitcnt++`. When the increment makes `bitcnt == outBits`: RX_DATA <= the shifted value, pulse RX_VALID, go to DONE.
  - SHIFT, on `sck_fall` with `bitcnt ≥ 1`: `tx_shift <<= 1`, filling with 0.
  - SHIFT, on `cs_rise`: pulse FRAME_ERR, leave RX_DATA unchanged, go to IDLE.
  - DONE: ignore further SCK edges. On `cs_rise`, go to IDLE with no error.
- MISO = `tx_shift[outBits-1]` in SHIFT, otherwise 0.
- `bitcnt` width is clog2(outBits+1). It never wraps, because counting stops in DONE.
- Reset:
  - State goes to IDLE; all registers clear.
  - CSbar synchronizer and history flops reset to 0 (asserted), so a frame already in progress at reset release produces no `cs_fall`. That frame is ignored until CSbar goes high.
- Reset mid-frame: same behaviour. No RX_VALID and no FRAME_ERR.

## Timing
- Reset values: MISO 0, RX_DATA 0, RX_VALID 0, BUSY 0, FRAME_ERR 0.
- Input-to-strobe latency: 3 SYS_CLK cycles (2 synchronizer + 1 edge). Outputs are registered, so they act 1 cycle later.
- MISO MSB is valid 4 SYS_CLK cycles after CSbar falls.
- Master requirements:
  - SCK period ≥ 8 SYS_CLK periods.
  - CSbar-fall to first SCK rise ≥ 6 SYS_CLK periods.
  - Last SCK fall to CSbar rise ≥ 4 SYS_CLK periods.
- Each MISO bit changes 4 SYS_CLK cycles after the SCK fall, well within the SCK low half-period.
- RX_VALID is asserted 4 SYS_CLK cycles after the `outBits`-th SCK rise.
- BUSY rises with the SHIFT entry and falls on the cycle after `cs_rise` is detected.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the constant `SYNC_STAGES = 2`;
  - the `bitcnt` width function.
- Sub-module `spi_sync_edge`:
  - one instance per asynchronous input;
  - contents: the synchronizer chain plus a history flop;
  - outputs: the synced level, `rise` and `fall`;
  - parameter: reset level (0 for all three instances).
- The top level holds the FSM, the shift registers, `tx_hold` and the outputs.

## Test plan
- Basic exchange:
  - Stimulus: outBits=16; TX_LOAD with 16'hFAAF; master sends 16'hEBBE with SCK = SYS_CLK/8.
  - Response: RX_DATA = 16'hEBBE with a single RX_VALID pulse; master captures 16'hFAAF; BUSY high for the whole frame.
- Back-to-back frames:
  - Stimulus: 16'h1234 then 16'hABCD with no TX_LOAD in between.
  - Response: both words received with 2 RX_VALID pulses; MISO returns the same `tx_hold` word both times.
- Abort:
  - Stimulus: CSbar rises after 9 bits.
  - Response: one FRAME_ERR pulse, no RX_VALID, RX_DATA keeps its prior value; the next full frame succeeds.
- Extra clocks:
  - Stimulus: 20 SCK pulses in one frame.
  - Response: RX_DATA holds the first 16 bits; MISO = 0 after bit 16; one RX_VALID.
- Reset mid-frame:
  - Stimulus: assert SYS_RST after 5 bits and release while CSbar is still low.
  - Response: all outputs 0, the remaining bits are ignored, no RX_VALID; the next CSbar-low frame is received normally.
- Load collision:
  - Stimulus: TX_LOAD with 16'h5A5A on the same cycle as the `cs_fall` strobe.
  - Response: master receives 16'h5A5A.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the oversampled SPI mode-0 slave.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Bit counter must be able to hold the value n itself.
  function automatic int bitcnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_slave_device_if.sv
// SPI pins plus the local word-side handshake of the SPI slave.
interface spi_slave_device_if #(parameter int outBits = 16);

  logic               SCK;
  logic               CSbar;
  logic               MOSI;
  logic               MISO;
  logic [outBits-1:0] TX_DATA;
  logic               TX_LOAD;
  logic [outBits-1:0] RX_DATA;
  logic               RX_VALID;
  logic               BUSY;
  logic               FRAME_ERR;

  modport slave (
    input  SCK, CSbar, MOSI, TX_DATA, TX_LOAD,
    output MISO, RX_DATA, RX_VALID, BUSY, FRAME_ERR
  );

  modport master (
    output SCK, CSbar, MOSI, TX_DATA, TX_LOAD,
    input  MISO, RX_DATA, RX_VALID, BUSY, FRAME_ERR
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer chain plus history flop; emits registered one-cycle edge strobes
// aligned with the delayed level output.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RST_LVL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_LVL}};
      r_hist <= RST_LVL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_hist;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_device.sv
// SPI mode-0 slave: shifts a word in on MOSI while returning the held word on MISO,
// with all SPI pins oversampled on the system clock.
module spi_slave_device
  import spi_slave_pkg::*;
#(
  parameter int outBits = 16
) (
  input logic               SYS_CLK,
  input logic               SYS_RST,
  spi_slave_device_if.slave bus
);

  localparam int             CW       = bitcnt_width(outBits);
  localparam logic [CW-1:0]  LAST_CNT = CW'(outBits);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [outBits-1:0] r_tx_hold;
  logic [outBits-1:0] r_tx_shift;
  logic [outBits-1:0] r_rx_shift;
  logic [outBits-1:0] r_rx_data;
  logic [CW-1:0]      r_bitcnt;
  logic               r_rx_valid;
  logic               r_frame_err;

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi_s;
  logic w_sck_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall;
  logic w_start, w_rx_shift_en, w_tx_shift_en, w_word_done, w_abort;
  logic [outBits-1:0] w_rx_nxt;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_unused_sync;

  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_sck (
    .i_clk(SYS_CLK), .i_rst(SYS_RST), .i_async(bus.SCK),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  // CSbar resets to "asserted" so a frame already running at reset release is ignored.
  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_cs (
    .i_clk(SYS_CLK), .i_rst(SYS_RST), .i_async(bus.CSbar),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.RST_LVL(1'b0)) u_sync_mosi (
    .i_clk(SYS_CLK), .i_rst(SYS_RST), .i_async(bus.MOSI),
    .o_level(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused_sync = w_sck_lvl ^ w_cs_lvl ^ w_mosi_rise ^ w_mosi_fall;
  assign w_rx_nxt      = {r_rx_shift[outBits-2:0], w_mosi_s};
  assign w_cnt_inc     = r_bitcnt + CNT_ONE;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_rx_shift_en = 1'b0;
    w_tx_shift_en = 1'b0;
    w_word_done   = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          if (w_sck_rise) begin
            w_rx_shift_en = 1'b1;
            if (w_cnt_inc == LAST_CNT) begin
              w_word_done = 1'b1;
              w_state_nxt = DONE;
            end
          end
          // MSB is already on MISO before the first rise, so shift only after one.
          if (w_sck_fall && (r_bitcnt != {CW{1'b0}})) begin
            w_tx_shift_en = 1'b1;
          end
        end
      end
      DONE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_tx_hold   <= {outBits{1'b0}};
      r_tx_shift  <= {outBits{1'b0}};
      r_rx_shift  <= {outBits{1'b0}};
      r_rx_data   <= {outBits{1'b0}};
      r_bitcnt    <= {CW{1'b0}};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_word_done;
      r_frame_err <= w_abort;
      if (bus.TX_LOAD) begin
        r_tx_hold <= bus.TX_DATA;
      end
      if (w_start) begin
        r_tx_shift <= bus.TX_LOAD ? bus.TX_DATA : r_tx_hold;
        r_bitcnt   <= {CW{1'b0}};
        r_rx_shift <= {outBits{1'b0}};
      end else begin
        if (w_tx_shift_en) begin
          r_tx_shift <= {r_tx_shift[outBits-2:0], 1'b0};
        end
        if (w_rx_shift_en) begin
          r_rx_shift <= w_rx_nxt;
          r_bitcnt   <= w_cnt_inc;
        end
      end
      if (w_word_done) begin
        r_rx_data <= w_rx_nxt;
      end
    end
  end

  assign bus.MISO      = (r_state == SHIFT) ? r_tx_shift[outBits-1] : 1'b0;
  assign bus.BUSY      = (r_state != IDLE);
  assign bus.RX_DATA   = r_rx_data;
  assign bus.RX_VALID  = r_rx_valid;
  assign bus.FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_spi_slave_device.sv
// Directed bench for spi_slave_device: acts as the SPI master with SCK = SYS_CLK/8.
module tb_spi_slave_device;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rv_cnt;
  int   fe_cnt;

  spi_slave_device_if #(.outBits(16)) bus ();

  spi_slave_device #(.outBits(16)) dut (
    .SYS_CLK(clk),
    .SYS_RST(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.RX_VALID)  rv_cnt++;
    if (bus.FRAME_ERR) fe_cnt++;
  end

  task automatic tx_load(input logic [15:0] d);
    @(negedge clk);
    bus.TX_DATA = d;
    bus.TX_LOAD = 1'b1;
    @(negedge clk);
    bus.TX_LOAD = 1'b0;
  endtask

  // One SCK period: MOSI set, MISO sampled just before the rising edge.
  task automatic sck_bit(input logic mosi, output logic miso, output logic busy);
    bus.MOSI = mosi;
    repeat (4) @(negedge clk);
    miso = bus.MISO;
    busy = bus.BUSY;
    bus.SCK = 1'b1;
    repeat (4) @(negedge clk);
    bus.SCK = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] tx, input int nbits, input bit coll,
                      input logic [15:0] coll_data, output logic [31:0] rx, output bit busy_ok);
    logic m, b;
    rx = 32'h0;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.CSbar = 1'b0;
    repeat (3) @(negedge clk);
    if (coll) begin
      bus.TX_DATA = coll_data;
      bus.TX_LOAD = 1'b1;
    end
    @(negedge clk);
    bus.TX_LOAD = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck_bit((i < 16) ? tx[15-i] : 1'b1, m, b);
      rx = {rx[30:0], m};
      if (!b) busy_ok = 1'b0;
    end
    repeat (6) @(negedge clk);
    bus.CSbar = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.SCK = 1'b0; bus.CSbar = 1'b1; bus.MOSI = 1'b0;
    bus.TX_DATA = 16'h0; bus.TX_LOAD = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.MISO !== 1'b0)      begin errors++; $display("FAIL reset_miso got %b exp 0", bus.MISO); end
    checks++; if (bus.RX_DATA !== 16'h0)  begin errors++; $display("FAIL reset_rx_data got %h exp 0000", bus.RX_DATA); end
    checks++; if (bus.RX_VALID !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b exp 0", bus.RX_VALID); end
    checks++; if (bus.BUSY !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", bus.FRAME_ERR); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] rx; bit bok; int rv0, fe0;
    tx_load(16'hFAAF);
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(16'hEBBE, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (rx[15:0] !== 16'hFAAF)   begin errors++; $display("FAIL basic_miso got %h exp FAAF", rx[15:0]); end
    checks++; if (bus.RX_DATA !== 16'hEBBE) begin errors++; $display("FAIL basic_rx_data got %h exp EBBE", bus.RX_DATA); end
    checks++; if (rv_cnt - rv0 !== 1)       begin errors++; $display("FAIL basic_rx_valid got %0d exp 1", rv_cnt - rv0); end
    checks++; if (fe_cnt - fe0 !== 0)       begin errors++; $display("FAIL basic_frame_err got %0d exp 0", fe_cnt - fe0); end
    checks++; if (bok !== 1'b1)             begin errors++; $display("FAIL basic_busy_frame got %b exp 1", bok); end
    checks++; if (bus.BUSY !== 1'b0)        begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.BUSY); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rx; bit bok; int rv0;
    rv0 = rv_cnt;
    xfer(16'h1234, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (rx[15:0] !== 16'hFAAF)   begin errors++; $display("FAIL b2b_miso1 got %h exp FAAF", rx[15:0]); end
    checks++; if (bus.RX_DATA !== 16'h1234) begin errors++; $display("FAIL b2b_rx1 got %h exp 1234", bus.RX_DATA); end
    xfer(16'hABCD, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (rx[15:0] !== 16'hFAAF)   begin errors++; $display("FAIL b2b_miso2 got %h exp FAAF", rx[15:0]); end
    checks++; if (bus.RX_DATA !== 16'hABCD) begin errors++; $display("FAIL b2b_rx2 got %h exp ABCD", bus.RX_DATA); end
    checks++; if (rv_cnt - rv0 !== 2)       begin errors++; $display("FAIL b2b_rx_valid got %0d exp 2", rv_cnt - rv0); end
  endtask

  task automatic test_abort;
    logic [31:0] rx; bit bok; int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(16'h5555, 9, 1'b0, 16'h0, rx, bok);
    checks++; if (fe_cnt - fe0 !== 1)       begin errors++; $display("FAIL abort_frame_err got %0d exp 1", fe_cnt - fe0); end
    checks++; if (rv_cnt - rv0 !== 0)       begin errors++; $display("FAIL abort_rx_valid got %0d exp 0", rv_cnt - rv0); end
    checks++; if (bus.RX_DATA !== 16'hABCD) begin errors++; $display("FAIL abort_rx_hold got %h exp ABCD", bus.RX_DATA); end
    checks++; if (rx[8:0] !== 9'h1F5)       begin errors++; $display("FAIL abort_miso got %h exp 1f5", rx[8:0]); end
    rv0 = rv_cnt;
    xfer(16'h0F0F, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (bus.RX_DATA !== 16'h0F0F) begin errors++; $display("FAIL abort_next_rx got %h exp 0F0F", bus.RX_DATA); end
    checks++; if (rv_cnt - rv0 !== 1)       begin errors++; $display("FAIL abort_next_valid got %0d exp 1", rv_cnt - rv0); end
  endtask

  task automatic test_extra_clocks;
    logic [31:0] rx; bit bok; int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(16'h3C3C, 20, 1'b0, 16'h0, rx, bok);
    checks++; if (rx[19:4] !== 16'hFAAF)    begin errors++; $display("FAIL extra_miso got %h exp FAAF", rx[19:4]); end
    checks++; if (rx[3:0] !== 4'h0)         begin errors++; $display("FAIL extra_miso_tail got %h exp 0", rx[3:0]); end
    checks++; if (bus.RX_DATA !== 16'h3C3C) begin errors++; $display("FAIL extra_rx got %h exp 3C3C", bus.RX_DATA); end
    checks++; if (rv_cnt - rv0 !== 1)       begin errors++; $display("FAIL extra_rx_valid got %0d exp 1", rv_cnt - rv0); end
    checks++; if (fe_cnt - fe0 !== 0)       begin errors++; $display("FAIL extra_frame_err got %0d exp 0", fe_cnt - fe0); end
    checks++; if (bok !== 1'b1)             begin errors++; $display("FAIL extra_busy got %b exp 1", bok); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rx; logic [15:0] w; bit bok, miso_zero; logic m, b; int rv0, fe0;
    w = 16'hA5C3;
    tx_load(16'h1357);
    rv0 = rv_cnt; fe0 = fe_cnt;
    @(negedge clk);
    bus.CSbar = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) sck_bit(w[15-i], m, b);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({bus.MISO, bus.RX_VALID, bus.BUSY, bus.FRAME_ERR} !== 4'b0000)
      begin errors++; $display("FAIL rstmid_outputs got %b exp 0000", {bus.MISO, bus.RX_VALID, bus.BUSY, bus.FRAME_ERR}); end
    checks++; if (bus.RX_DATA !== 16'h0) begin errors++; $display("FAIL rstmid_rx_data got %h exp 0000", bus.RX_DATA); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    miso_zero = 1'b1;
    for (int i = 5; i < 16; i++) begin
      sck_bit(w[15-i], m, b);
      if (m !== 1'b0 || b !== 1'b0) miso_zero = 1'b0;
    end
    repeat (6) @(negedge clk);
    bus.CSbar = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (miso_zero !== 1'b1)   begin errors++; $display("FAIL rstmid_ignored got %b exp 1", miso_zero); end
    checks++; if (rv_cnt - rv0 !== 0)   begin errors++; $display("FAIL rstmid_rx_valid got %0d exp 0", rv_cnt - rv0); end
    checks++; if (fe_cnt - fe0 !== 0)   begin errors++; $display("FAIL rstmid_frame_err got %0d exp 0", fe_cnt - fe0); end
    checks++; if (bus.RX_DATA !== 16'h0) begin errors++; $display("FAIL rstmid_rx_after got %h exp 0000", bus.RX_DATA); end
    tx_load(16'h2468);
    xfer(16'h9876, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (bus.RX_DATA !== 16'h9876) begin errors++; $display("FAIL rstmid_next_rx got %h exp 9876", bus.RX_DATA); end
    checks++; if (rx[15:0] !== 16'h2468)   begin errors++; $display("FAIL rstmid_next_miso got %h exp 2468", rx[15:0]); end
    checks++; if (rv_cnt - rv0 !== 1)       begin errors++; $display("FAIL rstmid_next_valid got %0d exp 1", rv_cnt - rv0); end
  endtask

  task automatic test_load_collision;
    logic [31:0] rx; bit bok;
    tx_load(16'h1111);
    xfer(16'h0001, 16, 1'b1, 16'h5A5A, rx, bok);
    checks++; if (rx[15:0] !== 16'h5A5A)   begin errors++; $display("FAIL coll_miso got %h exp 5A5A", rx[15:0]); end
    checks++; if (bus.RX_DATA !== 16'h0001) begin errors++; $display("FAIL coll_rx got %h exp 0001", bus.RX_DATA); end
    xfer(16'h0002, 16, 1'b0, 16'h0, rx, bok);
    checks++; if (rx[15:0] !== 16'h5A5A)   begin errors++; $display("FAIL coll_hold got %h exp 5A5A", rx[15:0]); end
  endtask

  initial begin
    checks = 0; errors = 0; rv_cnt = 0; fe_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_extra_clocks();
    test_reset_mid_frame();
    test_load_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
